// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus sequencer.
package stim_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;
    localparam int TIMER_W = 8;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stim_seq_if.sv
// Sequencer-side bundle: sweep control, vector to the DUT, response and check results.
interface stim_seq_if;
    import stim_pkg::*;

    logic             start;
    logic             pause;
    logic             f_in;
    logic [VEC_W-1:0] vec_out;
    logic             vec_valid;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_count;
    logic             mismatch;

    modport master (
        output start, pause, f_in,
        input  vec_out, vec_valid, busy, done, err_count, mismatch
    );

    modport slave (
        input  start, pause, f_in,
        output vec_out, vec_valid, busy, done, err_count, mismatch
    );

endinterface

// File: rtl/hold_timer.sv
// Per-vector hold timer: counts enabled cycles, flags terminal count at HOLD_CYCLES-1.
module hold_timer
    import stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TIMER_W'(1);
        end
    end

    assign o_tc = (r_cnt == TIMER_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/stim_seq.sv
// Exhaustive 4-input stimulus sequencer with optional response checker.
// Build option: define STIM_CHECK_EN to include the TRUTH comparison and error counter.
//
//   state | meaning
//   IDLE  | after reset, waiting for start; vec_out holds
//   DRIVE | presenting vectors 0..15, HOLD_CYCLES unpaused cycles each
//   DONE  | sweep finished, vec_out holds 15; start re-runs the sweep
module stim_seq
    import stim_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 10,
    parameter logic [NUM_VEC-1:0] TRUTH       = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    stim_seq_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [VEC_W-1:0] r_vec;
    logic             w_load;
    logic             w_run;
    logic             w_step;
    logic             w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run       = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            DRIVE: begin
                w_run  = !bus.pause;
                w_step = !bus.pause && w_tc;
                if (w_step && (r_vec == LAST_VEC)) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The last vector stays on the bus after the sweep; no wrap to 0.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_vec <= '0;
        end else if (w_step && (r_vec != LAST_VEC)) begin
            r_vec <= r_vec + VEC_W'(1);
        end
    end

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_run),
        .i_clr (w_load || w_step),
        .o_tc  (w_tc)
    );

    assign bus.vec_out   = r_vec;
    assign bus.busy      = (r_state == DRIVE);
    assign bus.vec_valid = (r_state == DRIVE);
    assign bus.done      = (r_state == DONE);

`ifdef STIM_CHECK_EN
    logic [ERR_W-1:0] r_err;
    logic             r_mismatch;
    logic             w_miss;

    assign w_miss = w_step && (bus.f_in != TRUTH[r_vec]);

    // Count saturates at one error per vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_miss;
            if (w_load) begin
                r_err <= '0;
            end else if (w_miss && (r_err != ERR_W'(NUM_VEC))) begin
                r_err <= r_err + ERR_W'(1);
            end
        end
    end

    assign bus.err_count = r_err;
    assign bus.mismatch  = r_mismatch;
`else
    logic w_unused_chk;
    assign w_unused_chk  = bus.f_in ^ (^TRUTH);
    assign bus.err_count = '0;
    assign bus.mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_stim_seq.sv
// Directed self-checking bench for stim_seq; expectations follow the checker build option.
module tb_stim_seq;
    import stim_pkg::*;

    localparam int          HOLD    = 10;
    localparam logic [15:0] TRUTH_P = 16'hA5C3;
`ifdef STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r_truth = TRUTH_P;
    logic [15:0] r_inj   = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    stim_seq_if bus ();

    stim_seq #(
        .HOLD_CYCLES (HOLD),
        .TRUTH       (TRUTH_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Golden downstream DUT, optionally corrupted on selected vectors.
    assign bus.f_in = r_truth[bus.vec_out] ^ r_inj[bus.vec_out];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full sweep from IDLE/DONE with a per-cycle reference model of unpaused cycles.
    task automatic sweep(input logic [15:0] inj, input int p_lo, input int p_hi,
                         input int s_at, input int exp_len, input int exp_v5);
        int   u;
        int   c;
        int   e;
        int   v5;
        logic mm;
        r_inj     = inj;
        bus.pause = (p_lo == 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("start_busy", bus.busy, 1);
        check("start_vec", bus.vec_out, 0);
        check("start_err", bus.err_count, 0);
        u  = 0;
        c  = 0;
        e  = 0;
        v5 = 0;
        while (u < 16 * HOLD && c < 400) begin
            c++;
            bus.pause = (c >= p_lo) && (c <= p_hi);
            bus.start = (c == s_at);
            tick;
            mm = 1'b0;
            if (!bus.pause) begin
                u++;
                if (u % HOLD == 0) mm = CHK && inj[u / HOLD - 1];
            end
            if (mm && e < 16) e++;
            check("vec", bus.vec_out, (u < 16 * HOLD) ? u / HOLD : 15);
            check("busy", bus.busy, (u < 16 * HOLD) ? 1 : 0);
            check("valid", bus.vec_valid, (u < 16 * HOLD) ? 1 : 0);
            check("done", bus.done, (u < 16 * HOLD) ? 0 : 1);
            check("mismatch", bus.mismatch, mm);
            check("err", bus.err_count, e);
            if (bus.vec_out == 4'd5) v5++;
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        check("sweep_len", c, exp_len);
        check("vec5_hold", v5, exp_v5);
        repeat (3) tick;
        check("done_hold", bus.done, 1);
        check("done_vec", bus.vec_out, 15);
        check("done_busy", bus.busy, 0);
        check("done_err", bus.err_count, e);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        repeat (2) tick;
        check("rst_vec", bus.vec_out, 0);
        check("rst_valid", bus.vec_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_mm", bus.mismatch, 0);
        bus.start = 1'b1;
        tick;
        check("rst_over_start", bus.busy, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick;
        check("idle_busy", bus.busy, 0);
        check("idle_vec", bus.vec_out, 0);

        // Plain sweep, golden response.
        sweep(16'h0000, -1, -2, -1, 160, 10);
        // Responses corrupted on vectors 3 and 12.
        sweep(16'h1008, -1, -2, -1, 160, 10);
        // Pause for 7 cycles in the middle of vector 5.
        sweep(16'h0000, 53, 59, -1, 167, 17);
        // Every response wrong: count reaches 16.
        sweep(16'hFFFF, -1, -2, -1, 160, 10);

        // Reset in the middle of vector 9, with start and pause also high.
        r_inj     = 16'h0008;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (90) tick;
        check("mid_vec", bus.vec_out, 9);
        check("mid_err", bus.err_count, CHK ? 1 : 0);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.pause = 1'b1;
        tick;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_vec", bus.vec_out, 0);
        check("midrst_err", bus.err_count, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        tick;
        check("postrst_busy", bus.busy, 0);

        // Restart; start pulse at vector 4 must be ignored.
        sweep(16'h0008, -1, -2, 46, 160, 10);
        // Restart from DONE with start and pause together; count clears.
        sweep(16'h0000, 0, 2, -1, 162, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, number of clock cycles each input vector is held; legal range 2..255.
REQ-002 Parameter TRUTH, default 16'h0000, expected DUT output per vector, where bit i is the expected F for vector i.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a sweep; sampled only in IDLE or DONE.
REQ-006 pause  input  1  level; while high, the hold timer and vector index freeze.
REQ-007 f_in  input  1  response from the downstream combinational DUT.
REQ-008 vec_out  output  4  vector driven to DUT: bit3=A, bit2=B, bit1=C, bit0=D.
REQ-009 vec_valid  output  1  high while vec_out carries a vector under test.
REQ-010 busy  output  1  high in DRIVE state.
REQ-011 done  output  1  high in DONE state.
REQ-012 err_count  output  5  number of mismatches in the current or last sweep, range 0..16.
REQ-013 mismatch  output  1  one-cycle pulse on each sampled mismatch.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DRIVE and DONE.
REQ-015 IDLE->DRIVE on start=1; vec_out<=0, hold timer<=0, err_count<=0 on the same edge.
REQ-016 In DRIVE with pause=0, the hold timer SHALL increment each cycle; with pause=1, the timer, vector and outputs SHALL hold.
REQ-017 When the timer reaches HOLD_CYCLES-1 with pause=0, f_in SHALL be sampled, the timer SHALL clear, and vec_out SHALL increment by 1.
REQ-018 When sampling vector 15, DRIVE SHALL go to DONE; vec_out SHALL NOT wrap to 0 in DRIVE.
REQ-019 Each vector SHALL be presented for exactly HOLD_CYCLES unpaused cycles; a full sweep SHALL take 16*HOLD_CYCLES unpaused cycles from the start edge to the DONE entry.
REQ-020 vec_valid SHALL equal busy; in IDLE and DONE, vec_out SHALL hold its last value.
REQ-021 DONE->DRIVE on start=1, with the same initialisation as REQ-015; DONE otherwise persists.
REQ-022 start asserted while in DRIVE SHALL be ignored.
REQ-023 err_count SHALL saturate at 16 and SHALL never wrap.
REQ-024 Simultaneous start and pause in IDLE: enter DRIVE; the first cycle is counted only if pause=0 on that cycle.

Reset
REQ-025 On rst=1: state=IDLE, vec_out=0, vec_valid=0, busy=0, done=0, err_count=0, mismatch=0, timer=0.
REQ-026 rst SHALL take priority over start and pause in all states, including mid-sweep in DRIVE.

Configuration
REQ-027 Macro STIM_CHECK_EN: when defined, the checker SHALL compare the sampled f_in with TRUTH[vec_out], driving mismatch and err_count.
REQ-028 When STIM_CHECK_EN is undefined, no compare logic SHALL be present, mismatch SHALL be tied to 0 and err_count SHALL be tied to 0; sequencing SHALL be unchanged.

Structure
REQ-029 Package stim_pkg SHALL hold the state enum (IDLE, DRIVE, DONE), localparam NUM_VEC=16 and the vector width constant VEC_W=4.
REQ-030 Sub-module hold_timer SHALL be used: a counter with enable (!pause), clear and terminal-count output at HOLD_CYCLES-1.

Verification
REQ-031 HOLD_CYCLES=10, start pulse -> vec_out steps 0..15 every 10 cycles; done rises 160 cycles after the start edge; busy=0 thereafter.
REQ-032 STIM_CHECK_EN defined, TRUTH=16'hA5C3, f_in driven by a golden model -> err_count=0 and no mismatch pulses.
REQ-033 STIM_CHECK_EN defined, TRUTH=16'hA5C3, f_in inverted on vectors 3 and 12 only -> two mismatch pulses, err_count=2.
REQ-034 pause high for 7 cycles during vector 5 -> vector 5 held for 17 cycles; done rises at 167 cycles.
REQ-035 rst pulsed at vector 9 -> next cycle IDLE, vec_out=0 and err_count=0; a new start restarts the sweep from 0.
REQ-036 start pulsed during DRIVE at vector 4, then again in DONE -> the first pulse is ignored; the second begins a fresh sweep with err_count cleared.
